// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, baud table and divisor helper.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

   localparam int DATA_BITS = 8;
   localparam int BAUD_4800 = 4800;
   localparam int BAUD_9600 = 9600;
   localparam int BAUD_19200 = 19200;
   localparam int BAUD_38400 = 38400;

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE, START, DATA, STOP
   } state_t;
`endif

   // Each branch divides by a constant so no runtime divider is built.
   function automatic int baud_div(input int clk_freq,
                                   input logic [1:0] sel);
      int div;
      unique case (sel)
         2'b00: div = clk_freq / BAUD_4800;
         2'b01: div = clk_freq / BAUD_9600;
         2'b10: div = clk_freq / BAUD_19200;
         2'b11: div = clk_freq / BAUD_38400;
         default: div = clk_freq / BAUD_4800;
      endcase
      return div;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Loadable down-counter; tick is high while the count sits at zero.
// Shared between the UART transmit and receive paths.
module uart_baud_tick #(
   parameter int DIV_W = 14
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [DIV_W-1:0] load_val,
   output logic             tick
);

   logic [DIV_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - DIV_W'(1);
      end
   end

   assign tick = (cnt == '0);

endmodule

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter, LSB first, valid/ready byte input.
// Define UART_TX_PARITY_EN to append an even-parity bit before STOP.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 50000000,
   parameter int DIV_W = 14
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] din,
   input  logic       din_valid,
   output logic       din_ready,
   input  logic [1:0] baud_sel,
   output logic       dout,
   output logic       busy
);

   state_t                 state;
   logic [DATA_BITS-1:0]   shift;
   logic [2:0]             idx;
   logic [DIV_W-1:0]       div_q;
   logic [DIV_W-1:0]       load_val;
   logic                   tick;
   logic                   load;
   logic                   accept;
`ifdef UART_TX_PARITY_EN
   logic                   par;
`endif

   assign accept = din_valid && din_ready;
   // Reload on acceptance and on every bit boundary (state entry).
   assign load = accept || (tick && state != IDLE);
   assign load_val = accept
      ? DIV_W'(baud_div(CLK_FREQ, baud_sel) - 1)
      : div_q - DIV_W'(1);

   uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (load_val),
      .tick     (tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         dout      <= 1'b1;
         din_ready <= 1'b1;
         busy      <= 1'b0;
         shift     <= '0;
         idx       <= '0;
         div_q     <= '0;
`ifdef UART_TX_PARITY_EN
         par       <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  state     <= START;
                  dout      <= 1'b0;
                  din_ready <= 1'b0;
                  busy      <= 1'b1;
                  shift     <= din;
                  idx       <= '0;
                  div_q     <= DIV_W'(baud_div(CLK_FREQ, baud_sel));
`ifdef UART_TX_PARITY_EN
                  par       <= ^din;
`endif
               end
            end
            START: begin
               if (tick) begin
                  state <= DATA;
                  dout  <= shift[0];
               end
            end
            DATA: begin
               if (tick) begin
                  idx <= idx + 3'd1;
                  if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     state <= PARITY;
                     dout  <= par;
`else
                     state <= STOP;
                     dout  <= 1'b1;
`endif
                  end else begin
                     dout  <= shift[1];
                     shift <= shift >> 1;
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (tick) begin
                  state <= STOP;
                  dout  <= 1'b1;
               end
            end
`endif
            STOP: begin
               if (tick) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  din_ready <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               dout  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: table, hand sequences, random.
// Uses a scaled CLK_FREQ so divisors are 20/10/5/2 cycles per bit.
module tb_uart_tx_serializer;

   localparam int CLK_FREQ = 96000;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] din;
   logic       din_valid;
   logic       din_ready;
   logic [1:0] baud_sel;
   logic       dout;
   logic       busy;

   int tests = 0;
   int fails = 0;
   int divs [4] = '{20, 10, 5, 2};

   uart_tx_serializer #(.CLK_FREQ(CLK_FREQ), .DIV_W(14)) dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .baud_sel  (baud_sel),
      .dout      (dout),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      logic [1:0] sel;
      int         div;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference frame: start, data LSB first, optional even parity, stop.
   function automatic void frame_bits(input logic [7:0] d,
                                      output bit b [NB]);
      b[0] = 1'b0;
      for (int i = 0; i < 8; i++) b[1 + i] = d[i];
      if (NB == 11) b[9] = ^d;
      b[NB - 1] = 1'b1;
   endfunction

   // Caller has driven din/din_valid/baud_sel at a negedge; the byte is
   // accepted at the next posedge and checked every cycle to idle.
   task automatic run_frame(input string name, input logic [7:0] d,
                            input int div, input bit keep_valid,
                            input bit chg_sel, input bit glitch);
      bit b [NB];
      int mis = 0;
      int k;
      frame_bits(d, b);
      chk({name, "_ready_pre"}, int'(din_ready), 1);
      for (k = 0; k < NB * div; k++) begin
         @(negedge clk);
         if (k == 0 && !keep_valid) din_valid = 1'b0;
         if (chg_sel && k == 3 * div) baud_sel = 2'b00;
         if (glitch && k == 4 * div) begin
            din = 8'h00;
            din_valid = 1'b1;
         end
         if (glitch && k == 4 * div + 1) din_valid = 1'b0;
         if (dout !== b[k / div] || busy !== 1'b1 || din_ready !== 1'b0)
            mis++;
      end
      chk({name, "_wave_errs"}, mis, 0);
      @(negedge clk);
      chk({name, "_idle_dout"}, int'(dout), 1);
      chk({name, "_idle_busy"}, int'(busy), 0);
      chk({name, "_idle_ready"}, int'(din_ready), 1);
   endtask

   vec_t vecs [4];

   initial begin
      int mis;
      vecs[0] = '{d: 8'h63, sel: 2'b00, div: 20};
      vecs[1] = '{d: 8'h00, sel: 2'b01, div: 10};
      vecs[2] = '{d: 8'hFF, sel: 2'b10, div: 5};
      vecs[3] = '{d: 8'hA5, sel: 2'b11, div: 2};

      // Divisor helper at the production clock
      chk("div50_4800", uart_pkg::baud_div(50000000, 2'b00), 10416);
      chk("div50_9600", uart_pkg::baud_div(50000000, 2'b01), 5208);
      chk("div50_19200", uart_pkg::baud_div(50000000, 2'b10), 2604);
      chk("div50_38400", uart_pkg::baud_div(50000000, 2'b11), 1302);

      rst = 1'b1;
      din = 8'h00;
      din_valid = 1'b0;
      baud_sel = 2'b00;
      #12;
      chk("rst_dout", int'(dout), 1);
      chk("rst_ready", int'(din_ready), 1);
      chk("rst_busy", int'(busy), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 4; i++) begin
         din = vecs[i].d;
         baud_sel = vecs[i].sel;
         din_valid = 1'b1;
         run_frame($sformatf("vec%0d", i), vecs[i].d, vecs[i].div,
                   1'b0, 1'b0, 1'b0);
      end

      // Back-to-back with din_valid held: one idle-high cycle between
      din = 8'h63;
      baud_sel = 2'b00;
      din_valid = 1'b1;
      run_frame("b2b_first", 8'h63, 20, 1'b1, 1'b0, 1'b0);
      din = 8'h8E;
      run_frame("b2b_second", 8'h8E, 20, 1'b0, 1'b0, 1'b0);

      // Mid-frame baud change must not affect the current frame
      din = 8'hA5;
      baud_sel = 2'b11;
      din_valid = 1'b1;
      run_frame("sel_change", 8'hA5, 2, 1'b0, 1'b1, 1'b0);

      // din_valid pulse while busy is ignored
      din = 8'h5C;
      baud_sel = 2'b01;
      din_valid = 1'b1;
      run_frame("busy_pulse", 8'h5C, 10, 1'b0, 1'b0, 1'b1);

      // Reset during data bit 4 abandons the frame
      din = 8'hFF;
      baud_sel = 2'b11;
      din_valid = 1'b1;
      @(negedge clk);
      din_valid = 1'b0;
      repeat (10) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("midrst_dout", int'(dout), 1);
      chk("midrst_ready", int'(din_ready), 1);
      chk("midrst_busy", int'(busy), 0);
      @(negedge clk);
      rst = 1'b0;
      mis = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (dout !== 1'b1 || busy !== 1'b0 || din_ready !== 1'b1) mis++;
      end
      chk("midrst_quiet", mis, 0);

      // Randomized bytes, baud rates and idle gaps
      for (int r = 0; r < 20; r++) begin
         logic [7:0] rd;
         logic [1:0] rs;
         repeat ($urandom_range(0, 3)) @(negedge clk);
         rd = 8'($urandom);
         rs = 2'($urandom_range(0, 3));
         din = rd;
         baud_sel = rs;
         din_valid = 1'b1;
         run_frame($sformatf("rnd%0d", r), rd, divs[rs],
                   1'b0, 1'b0, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
